// File: rtl/gcn_result_streamer.sv
// gcn_result_streamer: snapshots the GCN argmax labels on done and
// streams them one node per beat, keeping a per-class histogram.
module gcn_result_streamer #(
    parameter int FEATURE_ROWS      = 6,
    parameter int WEIGHT_COLS       = 3,
    parameter int MAX_ADDRESS_WIDTH = 2,
    parameter int NODE_WIDTH        = $clog2(FEATURE_ROWS),
    parameter int CNT_WIDTH         = $clog2(FEATURE_ROWS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         done_in,
    input  logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NODE_WIDTH-1:0]        out_node,
    output logic [MAX_ADDRESS_WIDTH-1:0] out_class,
    output logic                         out_last,
    output logic [CNT_WIDTH-1:0]         class_hist [0:WEIGHT_COLS-1],
    output logic [CNT_WIDTH-1:0]         invalid_cnt,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FIN
    } state_t;

    localparam logic [NODE_WIDTH-1:0] LAST_NODE = NODE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    state_t                       state;
    state_t                       state_nx;
    logic                         done_d;
    logic                         start_ev;
    logic [NODE_WIDTH-1:0]        node_cnt;
    logic [MAX_ADDRESS_WIDTH-1:0] snap [0:FEATURE_ROWS-1];

    assign start_ev = done_in & ~done_d;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and beat outputs; beat fields are zero outside SEND
    always_comb begin
        state_nx   = state;
        out_valid  = 1'b0;
        out_node   = '0;
        out_class  = '0;
        out_last   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ev) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_node  = node_cnt;
                out_class = snap[node_cnt];
                out_last  = (node_cnt == LAST_NODE);
                if (out_ready && out_last) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Edge register, snapshot capture, node walk, histogram and overrun
    always_ff @(posedge clk) begin
        if (!reset) begin
            done_d      <= 1'b0;
            node_cnt    <= '0;
            invalid_cnt <= '0;
            overrun     <= 1'b0;
            for (int i = 0; i < FEATURE_ROWS; i++) begin
                snap[i] <= '0;
            end
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                class_hist[c] <= '0;
            end
        end else begin
            done_d <= done_in;
            if (start_ev && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (state == IDLE && start_ev) begin
                node_cnt    <= '0;
                invalid_cnt <= '0;
                for (int i = 0; i < FEATURE_ROWS; i++) begin
                    snap[i] <= max_addi_answer[i];
                end
                for (int c = 0; c < WEIGHT_COLS; c++) begin
                    class_hist[c] <= '0;
                end
            end else if (state == SEND && out_ready) begin
                if (int'(out_class) < WEIGHT_COLS) begin
                    for (int c = 0; c < WEIGHT_COLS; c++) begin
                        if (int'(out_class) == c) begin
                            class_hist[c] <= class_hist[c] + CNT_ONE;
                        end
                    end
                end else begin
                    invalid_cnt <= invalid_cnt + CNT_ONE;
                end
                if (!out_last) begin
                    node_cnt <= node_cnt + NODE_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gcn_result_streamer.sv
// Scoreboard bench for gcn_result_streamer: expected beats are queued
// at stimulus time and checked by an independent monitor.
module tb_gcn_result_streamer;

    localparam int FR = 6;
    localparam int WC = 3;
    localparam int AW = 2;
    localparam int NW = $clog2(FR);
    localparam int CW = $clog2(FR + 1);

    logic          clk;
    logic          reset;
    logic          done_in;
    logic [AW-1:0] max_addi_answer [0:FR-1];
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] out_node;
    logic [AW-1:0] out_class;
    logic          out_last;
    logic [CW-1:0] class_hist [0:WC-1];
    logic [CW-1:0] invalid_cnt;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    gcn_result_streamer #(
        .FEATURE_ROWS(FR),
        .WEIGHT_COLS(WC),
        .MAX_ADDRESS_WIDTH(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .done_in(done_in),
        .max_addi_answer(max_addi_answer),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_node(out_node),
        .out_class(out_class),
        .out_last(out_last),
        .class_hist(class_hist),
        .invalid_cnt(invalid_cnt),
        .busy(busy),
        .frame_done(frame_done),
        .overrun(overrun)
    );

    typedef struct {
        int node;
        int cls;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    checks;
    int    errors;
    int    ready_mode;
    int    lab [0:FR-1];
    bit    ovr_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Ready pattern driver
    initial begin
        int rc;
        rc = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (rc % 3 == 0);
                    rc++;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares accepted beats against the queue, checks stall hold
    initial begin
        bit    stalled;
        beat_t prev;
        beat_t e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_node", int'(out_node), prev.node);
                    chk("hold_class", int'(out_class), prev.cls);
                    chk("hold_last", int'(out_last), int'(prev.last));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", int'(out_node), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_node", int'(out_node), e.node);
                        chk("beat_class", int'(out_class), e.cls);
                        chk("beat_last", int'(out_last), int'(e.last));
                    end
                end
                stalled   = out_valid && !out_ready;
                prev.node = int'(out_node);
                prev.cls  = int'(out_class);
                prev.last = out_last;
            end
        end
    end

    task automatic push_frame();
        beat_t b;
        for (int i = 0; i < FR; i++) begin
            b.node = i;
            b.cls  = lab[i];
            b.last = (i == FR - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic apply_labels();
        for (int i = 0; i < FR; i++) begin
            max_addi_answer[i] = AW'(lab[i]);
        end
    endtask

    task automatic check_counts(input string tag);
        int h [0:WC-1];
        int inv;
        for (int c = 0; c < WC; c++) h[c] = 0;
        inv = 0;
        for (int i = 0; i < FR; i++) begin
            if (lab[i] < WC) h[lab[i]]++;
            else inv++;
        end
        for (int c = 0; c < WC; c++) begin
            chk($sformatf("%s_hist%0d", tag, c), int'(class_hist[c]), h[c]);
        end
        chk({tag, "_invalid"}, int'(invalid_cnt), inv);
    endtask

    task automatic run_frame(input int mode, input bit isolate, input bit ovr);
        int n;
        bit got;
        ready_mode = mode;
        push_frame();
        @(posedge clk);
        #1;
        done_in = 1'b0;
        apply_labels();
        @(posedge clk);
        #1;
        done_in = 1'b1;
        @(negedge clk);
        chk("early_valid", int'(out_valid), 0);
        n   = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("latency_valid", int'(out_valid), 1);
                if (isolate) begin
                    for (int i = 0; i < FR; i++) max_addi_answer[i] = 2'd2;
                end
            end
            if (ovr && n == 3) done_in = 1'b0;
            if (ovr && n == 4) done_in = 1'b1;
            if (frame_done) got = 1'b1;
        end
        chk("frame_done_seen", int'(got), 1);
        if (mode == 0) chk("frame_cycles", n, FR + 1);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        check_counts("fin");
        @(negedge clk);
        chk("frame_done_pulse", int'(frame_done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("overrun", int'(overrun), int'(ovr_exp));
        check_counts("hold");
    endtask

    initial begin
        int  n;
        bit  seen;
        checks     = 0;
        errors     = 0;
        ready_mode = 0;
        ovr_exp    = 1'b0;
        reset      = 1'b0;
        done_in    = 1'b0;
        for (int i = 0; i < FR; i++) lab[i] = 0;
        apply_labels();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_node", int'(out_node), 0);
        chk("rst_class", int'(out_class), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_invalid", int'(invalid_cnt), 0);
        for (int c = 0; c < WC; c++) chk("rst_hist", int'(class_hist[c]), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        lab = '{0, 1, 2, 1, 0, 2};
        run_frame(0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);

        lab = '{3, 3, 0, 1, 2, 3};
        run_frame(0, 1'b0, 1'b0);

        lab = '{1, 2, 0, 3, 2, 1};
        ovr_exp = 1'b1;
        run_frame(1, 1'b0, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("level_done_no_frame", int'(seen), 0);

        lab = '{0, 1, 0, 1, 0, 1};
        run_frame(0, 1'b1, 1'b0);

        lab = '{2, 2, 1, 0, 1, 2};
        ready_mode = 0;
        push_frame();
        @(posedge clk);
        #1;
        done_in = 1'b0;
        apply_labels();
        @(posedge clk);
        #1;
        done_in = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 50 && !seen) begin
            @(negedge clk);
            n++;
            if (out_valid && int'(out_node) == 3) seen = 1'b1;
        end
        chk("reach_beat3", int'(seen), 1);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        done_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        ovr_exp = 1'b0;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_invalid", int'(invalid_cnt), 0);
        for (int c = 0; c < WC; c++) chk("midrst_hist", int'(class_hist[c]), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_frame(0, 1'b0, 1'b0);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < FR; i++) lab[i] = int'($urandom_range(0, 3));
            run_frame(2, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
